geri_yaz_yazmac_obegi: RTL and testbench

GERI_YAZ_YAZMAC_OBEGI -- requirements
Module: geri_yaz_yazmac_obegi

---
 rtl/geri_yaz_yazmac_obegi.sv | 143 ++++++++++++++
 tb/tb_geri_yaz_yazmac_obegi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/geri_yaz_yazmac_obegi.sv
// -----------------------------------------------------------------------------
// geri_yaz_yazmac_obegi
// Writeback stage and 32x32 integer register file with write-through bypass,
// forwarding output and a retired-instruction counter.
//
// Ports
//   clk_i                  core clock, rising edge
//   rst_i                  asynchronous active-high reset
//   gy_gecerli_i           valid instruction in writeback
//   gy_mikroislem_i[2:0]   [0] write enable, [2:1] source select
//   gy_rd_adres_i          destination register
//   gy_rd_deger_i          ALU/divide/crypto result           (sel 00)
//   gy_ps_artmis_i[31:1]   incremented PC, halfword aligned    (sel 01)
//   gy_bib_deger_i         load result                         (sel 10)
//   gy_carpma_deger_i      multiplier result                   (sel 11)
//   ddb_durdur_i           stall; freezes register array and counter
//   cyo_rs1/2_adres_i      decode read addresses
//   cyo_rs1/2_deger_o      read data (combinational, bypassed)
//   gy_yonlendir_*_o       forwarding value / valid / address
//   sayac_emekli_o         retired-instruction count
// -----------------------------------------------------------------------------
module geri_yaz_yazmac_obegi #(
    parameter int unsigned SAYAC_BIT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 gy_gecerli_i,
    input  logic [2:0]           gy_mikroislem_i,
    input  logic [4:0]           gy_rd_adres_i,
    input  logic [31:0]          gy_rd_deger_i,
    input  logic [31:1]          gy_ps_artmis_i,
    input  logic [31:0]          gy_bib_deger_i,
    input  logic [31:0]          gy_carpma_deger_i,
    input  logic                 ddb_durdur_i,
    input  logic [4:0]           cyo_rs1_adres_i,
    input  logic [4:0]           cyo_rs2_adres_i,
    output logic [31:0]          cyo_rs1_deger_o,
    output logic [31:0]          cyo_rs2_deger_o,
    output logic [31:0]          gy_yonlendir_deger_o,
    output logic                 gy_yonlendir_gecerli_o,
    output logic [4:0]           gy_yonlendir_adres_o,
    output logic [SAYAC_BIT-1:0] sayac_emekli_o
);

    localparam int unsigned VERI_BIT      = 32;
    localparam int unsigned ADRES_BIT     = 5;
    localparam int unsigned YAZMAC_SAYISI = 32;

    localparam logic [1:0] SEC_RD    = 2'b00;
    localparam logic [1:0] SEC_PS    = 2'b01;
    localparam logic [1:0] SEC_BIB   = 2'b10;
    localparam logic [1:0] SEC_CARPMA = 2'b11;

    logic [VERI_BIT-1:0]  yazmac_q [YAZMAC_SAYISI];
    logic [VERI_BIT-1:0]  yazmac_d [YAZMAC_SAYISI];
    logic [SAYAC_BIT-1:0] sayac_q;
    logic [SAYAC_BIT-1:0] sayac_d;

    logic [VERI_BIT-1:0]  secilen_c;
    logic                 yonlendir_gecerli_c;
    logic                 yaz_c;
    logic                 emekli_c;

    // Writeback source mux
    always_comb begin
        secilen_c = gy_rd_deger_i;
        unique case (gy_mikroislem_i[2:1])
            SEC_RD:     secilen_c = gy_rd_deger_i;
            SEC_PS:     secilen_c = {gy_ps_artmis_i, 1'b0};
            SEC_BIB:    secilen_c = gy_bib_deger_i;
            SEC_CARPMA: secilen_c = gy_carpma_deger_i;
            default:    secilen_c = gy_rd_deger_i;
        endcase
    end

    // Forwarding ignores the stall so that decode can still see the value
    // that will be written once the stall releases.
    always_comb begin
        yonlendir_gecerli_c = gy_gecerli_i & gy_mikroislem_i[0]
                            & (gy_rd_adres_i != ADRES_BIT'(0));
        yaz_c               = yonlendir_gecerli_c & ~ddb_durdur_i;
        emekli_c            = gy_gecerli_i & ~ddb_durdur_i;
    end

    // Next-state for register array and retirement counter
    always_comb begin
        for (int i = 0; i < int'(YAZMAC_SAYISI); i++) begin
            yazmac_d[i] = yazmac_q[i];
        end
        sayac_d = sayac_q;
        if (yaz_c) begin
            yazmac_d[gy_rd_adres_i] = secilen_c;
        end
        if (emekli_c) begin
            sayac_d = sayac_q + SAYAC_BIT'(1);
        end
    end

    // State registers; entry 0 is never written because yaz_c excludes x0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(YAZMAC_SAYISI); i++) begin
                yazmac_q[i] <= '0;
            end
            sayac_q <= '0;
        end else begin
            for (int i = 0; i < int'(YAZMAC_SAYISI); i++) begin
                yazmac_q[i] <= yazmac_d[i];
            end
            sayac_q <= sayac_d;
        end
    end

    // Read port 1: reset forces zero and suppresses the bypass
    always_comb begin
        cyo_rs1_deger_o = '0;
        if (rst_i || (cyo_rs1_adres_i == ADRES_BIT'(0))) begin
            cyo_rs1_deger_o = '0;
        end else if (yaz_c && (cyo_rs1_adres_i == gy_rd_adres_i)) begin
            cyo_rs1_deger_o = secilen_c;
        end else begin
            cyo_rs1_deger_o = yazmac_q[cyo_rs1_adres_i];
        end
    end

    // Read port 2: independent of port 1
    always_comb begin
        cyo_rs2_deger_o = '0;
        if (rst_i || (cyo_rs2_adres_i == ADRES_BIT'(0))) begin
            cyo_rs2_deger_o = '0;
        end else if (yaz_c && (cyo_rs2_adres_i == gy_rd_adres_i)) begin
            cyo_rs2_deger_o = secilen_c;
        end else begin
            cyo_rs2_deger_o = yazmac_q[cyo_rs2_adres_i];
        end
    end

    assign gy_yonlendir_deger_o   = secilen_c;
    assign gy_yonlendir_gecerli_o = yonlendir_gecerli_c;
    assign gy_yonlendir_adres_o   = gy_rd_adres_i;
    assign sayac_emekli_o         = sayac_q;

endmodule

// File: tb/tb_geri_yaz_yazmac_obegi.sv
// -----------------------------------------------------------------------------
// tb_geri_yaz_yazmac_obegi
// Directed stimulus drives the writeback/register-file block after each rising
// edge and queues hand-computed expectations; a monitor pops and compares them
// at the following falling edge.
// -----------------------------------------------------------------------------
module tb_geri_yaz_yazmac_obegi;

    localparam int unsigned SB = 4;

    localparam int unsigned S_RS1 = 0;
    localparam int unsigned S_RS2 = 1;
    localparam int unsigned S_YD  = 2;
    localparam int unsigned S_YG  = 3;
    localparam int unsigned S_SAY = 4;
    localparam int unsigned S_YA  = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          gy_gecerli_i;
    logic [2:0]    gy_mikroislem_i;
    logic [4:0]    gy_rd_adres_i;
    logic [31:0]   gy_rd_deger_i;
    logic [31:1]   gy_ps_artmis_i;
    logic [31:0]   gy_bib_deger_i;
    logic [31:0]   gy_carpma_deger_i;
    logic          ddb_durdur_i;
    logic [4:0]    cyo_rs1_adres_i;
    logic [4:0]    cyo_rs2_adres_i;
    logic [31:0]   cyo_rs1_deger_o;
    logic [31:0]   cyo_rs2_deger_o;
    logic [31:0]   gy_yonlendir_deger_o;
    logic          gy_yonlendir_gecerli_o;
    logic [4:0]    gy_yonlendir_adres_o;
    logic [SB-1:0] sayac_emekli_o;

    geri_yaz_yazmac_obegi #(.SAYAC_BIT(SB)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .gy_gecerli_i          (gy_gecerli_i),
        .gy_mikroislem_i       (gy_mikroislem_i),
        .gy_rd_adres_i         (gy_rd_adres_i),
        .gy_rd_deger_i         (gy_rd_deger_i),
        .gy_ps_artmis_i        (gy_ps_artmis_i),
        .gy_bib_deger_i        (gy_bib_deger_i),
        .gy_carpma_deger_i     (gy_carpma_deger_i),
        .ddb_durdur_i          (ddb_durdur_i),
        .cyo_rs1_adres_i       (cyo_rs1_adres_i),
        .cyo_rs2_adres_i       (cyo_rs2_adres_i),
        .cyo_rs1_deger_o       (cyo_rs1_deger_o),
        .cyo_rs2_deger_o       (cyo_rs2_deger_o),
        .gy_yonlendir_deger_o  (gy_yonlendir_deger_o),
        .gy_yonlendir_gecerli_o(gy_yonlendir_gecerli_o),
        .gy_yonlendir_adres_o  (gy_yonlendir_adres_o),
        .sayac_emekli_o        (sayac_emekli_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       ad;
        int unsigned sec;
        logic [63:0] beklenen;
    } beklenti_t;

    beklenti_t sb[$];
    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    // Monitor: outputs are combinational, so every falling edge is a sample
    always @(negedge clk_i) begin
        while (sb.size() > 0) begin
            beklenti_t   e;
            logic [63:0] gercek;
            e = sb.pop_front();
            case (e.sec)
                S_RS1:   gercek = 64'(cyo_rs1_deger_o);
                S_RS2:   gercek = 64'(cyo_rs2_deger_o);
                S_YD:    gercek = 64'(gy_yonlendir_deger_o);
                S_YG:    gercek = 64'(gy_yonlendir_gecerli_o);
                S_SAY:   gercek = 64'(sayac_emekli_o);
                default: gercek = 64'(gy_yonlendir_adres_o);
            endcase
            kontrol_sayisi++;
            if (gercek !== e.beklenen) begin
                hata_sayisi++;
                $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                         e.ad, gercek, e.beklenen, $time);
            end
        end
    end

    task automatic bekle(input string ad, input int unsigned sec,
                         input logic [63:0] deger);
        beklenti_t e;
        e.ad = ad; e.sec = sec; e.beklenen = deger;
        sb.push_back(e);
    endtask

    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sur(input logic g, input logic [2:0] mi, input logic [4:0] rd,
                       input logic [31:0] rdd, input logic [31:1] ps,
                       input logic [31:0] bib, input logic [31:0] carp,
                       input logic dur, input logic [4:0] a1, input logic [4:0] a2);
        gy_gecerli_i      = g;
        gy_mikroislem_i   = mi;
        gy_rd_adres_i     = rd;
        gy_rd_deger_i     = rdd;
        gy_ps_artmis_i    = ps;
        gy_bib_deger_i    = bib;
        gy_carpma_deger_i = carp;
        ddb_durdur_i      = dur;
        cyo_rs1_adres_i   = a1;
        cyo_rs2_adres_i   = a2;
    endtask

    task automatic bos(input logic [4:0] a1, input logic [4:0] a2);
        sur(1'b0, 3'b000, 5'd0, 32'h0, 31'h0, 32'h0, 32'h0, 1'b0, a1, a2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        bos(5'd0, 5'd0);
        repeat (2) adim();
        rst_i = 1'b0;

        // All registers read zero after reset on both ports
        for (int i = 0; i < 32; i++) begin
            bos(5'(i), 5'(31 - i));
            bekle($sformatf("rst_rs1_x%0d", i), S_RS1, 64'h0);
            bekle($sformatf("rst_rs2_x%0d", 31 - i), S_RS2, 64'h0);
            if (i == 0) bekle("rst_sayac", S_SAY, 64'd0);
            adim();
        end

        // Write x5 with same-cycle bypass on both ports
        sur(1'b1, 3'b001, 5'd5, 32'hDEADBEEF, 31'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd5);
        bekle("bypass_rs1", S_RS1, 64'hDEADBEEF);
        bekle("bypass_rs2", S_RS2, 64'hDEADBEEF);
        bekle("x5_yon_deger", S_YD, 64'hDEADBEEF);
        bekle("x5_yon_gec", S_YG, 64'd1);
        bekle("x5_yon_adres", S_YA, 64'd5);
        bekle("x5_sayac_once", S_SAY, 64'd0);
        adim();
        bos(5'd5, 5'd0);
        bekle("x5_kalici", S_RS1, 64'hDEADBEEF);
        bekle("sayac_1", S_SAY, 64'd1);
        adim();

        // Select 01: PC+ halfword form, with distractor values on other sources
        sur(1'b1, 3'b011, 5'd1, 32'h11111111, 31'h40000002, 32'h22222222,
            32'h33333333, 1'b0, 5'd0, 5'd0);
        bekle("sel01_yon", S_YD, 64'h80000004);
        adim();
        sur(1'b1, 3'b101, 5'd2, 32'h11111111, 31'h7FFFFFFF, 32'h00000012,
            32'h33333333, 1'b0, 5'd0, 5'd0);
        bekle("sel10_yon", S_YD, 64'h12);
        adim();
        sur(1'b1, 3'b111, 5'd3, 32'h11111111, 31'h7FFFFFFF, 32'h22222222,
            32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        bekle("sel11_yon", S_YD, 64'hFFFFFFFF);
        adim();
        bos(5'd1, 5'd2);
        bekle("x1_oku", S_RS1, 64'h80000004);
        bekle("x2_oku", S_RS2, 64'h12);
        bekle("sayac_4", S_SAY, 64'd4);
        adim();
        bos(5'd3, 5'd5);
        bekle("x3_oku", S_RS1, 64'hFFFFFFFF);
        bekle("x5_oku", S_RS2, 64'hDEADBEEF);
        adim();

        // Write to x0: no effect, not forwarded, still retires
        sur(1'b1, 3'b001, 5'd0, 32'h1234, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        bekle("x0_rs1", S_RS1, 64'h0);
        bekle("x0_rs2", S_RS2, 64'h0);
        bekle("x0_yon_gec", S_YG, 64'd0);
        adim();
        bos(5'd0, 5'd0);
        bekle("x0_sayac_5", S_SAY, 64'd5);
        adim();

        // Stall for 3 cycles with a pending write to x7
        for (int i = 0; i < 3; i++) begin
            sur(1'b1, 3'b001, 5'd7, 32'hAA, 31'h0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd0);
            bekle($sformatf("stall%0d_x7", i), S_RS1, 64'h0);
            bekle($sformatf("stall%0d_yon_gec", i), S_YG, 64'd1);
            bekle($sformatf("stall%0d_yon_deger", i), S_YD, 64'hAA);
            bekle($sformatf("stall%0d_sayac", i), S_SAY, 64'd5);
            adim();
        end
        sur(1'b1, 3'b001, 5'd7, 32'hAA, 31'h0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd0);
        bekle("stall_birak_bypass", S_RS1, 64'hAA);
        adim();
        bos(5'd7, 5'd0);
        bekle("x7_oku", S_RS1, 64'hAA);
        bekle("sayac_6", S_SAY, 64'd6);
        adim();

        // Non-writing retirement, then a write-enabled but invalid slot
        sur(1'b1, 3'b000, 5'd9, 32'h99, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        bekle("magaza_yon_gec", S_YG, 64'd0);
        adim();
        sur(1'b0, 3'b001, 5'd9, 32'h99, 31'h0, 32'h0, 32'h0, 1'b0, 5'd9, 5'd0);
        bekle("gecersiz_yon_gec", S_YG, 64'd0);
        bekle("gecersiz_bypass_yok", S_RS1, 64'h0);
        adim();
        bos(5'd9, 5'd0);
        bekle("x9_yazilmadi", S_RS1, 64'h0);
        bekle("sayac_7", S_SAY, 64'd7);
        adim();

        // Retire up to 15, then wrap to 0, then one more to 1
        for (int i = 0; i < 8; i++) begin
            sur(1'b1, 3'b000, 5'd0, 32'h0, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
            adim();
        end
        bos(5'd0, 5'd0);
        bekle("sayac_15", S_SAY, 64'd15);
        sur(1'b1, 3'b000, 5'd0, 32'h0, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        adim();
        sur(1'b1, 3'b000, 5'd0, 32'h0, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        bekle("sayac_tasma_0", S_SAY, 64'd0);
        adim();
        bos(5'd0, 5'd0);
        bekle("sayac_1_tasmadan_sonra", S_SAY, 64'd1);
        adim();

        // Asynchronous reset between edges with a write pending to x5
        rst_i = 1'b1;
        sur(1'b1, 3'b001, 5'd5, 32'h55, 31'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd7);
        bekle("rst_bypass_yok", S_RS1, 64'h0);
        bekle("rst_x7", S_RS2, 64'h0);
        bekle("rst_sayac_0", S_SAY, 64'd0);
        adim();
        rst_i = 1'b0;
        bos(5'd5, 5'd1);
        bekle("rst_sonra_x5", S_RS1, 64'h0);
        bekle("rst_sonra_x1", S_RS2, 64'h0);
        bekle("rst_sonra_sayac", S_SAY, 64'd0);
        adim();

        // First write after reset release
        sur(1'b1, 3'b001, 5'd4, 32'hCAFE0001, 31'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        adim();
        bos(5'd4, 5'd0);
        bekle("ilk_yazma_x4", S_RS1, 64'hCAFE0001);
        bekle("ilk_yazma_sayac", S_SAY, 64'd1);
        adim();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            hata_sayisi++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
